// File: rtl/sdr_cmd_responder.sv
// SDR SDRAM device-side responder. It decodes the pin-level command bus and tracks mode and open rows.
// It runs burst reads/writes against a small byte-maskable array and latches the first protocol error.
module sdr_cmd_responder #(
  parameter int ROW_IDX_W = 4,
  parameter int COL_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdr_CKE,
  input  logic        sdr_nCS,
  input  logic [1:0]  sdr_BA,
  input  logic [12:0] sdr_A,
  input  logic        sdr_nRAS,
  input  logic        sdr_nCAS,
  input  logic        sdr_nWE,
  input  logic [1:0]  sdr_DQM,
  input  logic [15:0] sdr_DQ_in,
  output logic [15:0] sdr_DQ_out,
  output logic        sdr_DQ_oe,
  output logic        resp_err,
  output logic [2:0]  resp_err_code,
  output logic [15:0] aref_cnt
);
  localparam int MEM_AW = 2 + ROW_IDX_W + COL_IDX_W;

  localparam logic [2:0] CMD_MRS   = 3'b000;
  localparam logic [2:0] CMD_AREF  = 3'b001;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b101;

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} burst_t;

  logic [15:0]          mem [2**MEM_AW];
  logic [ROW_IDX_W-1:0] open_row [4];
  logic [3:0]           bank_open;
  logic                 mode_set;
  logic [2:0]           cl;
  logic [1:0]           bl_log;
  burst_t               burst_st;
  logic [2:0]           burst_left;
  logic [1:0]           burst_bank;
  logic [ROW_IDX_W-1:0] burst_row;
  logic [COL_IDX_W-1:0] burst_col;
  logic                 vld_p1, vld_p2, oe_p1, oe_p2;
  logic [15:0]          data_p1, data_p2;

  logic                 cmd_en, any_open, mrs_legal;
  logic [2:0]           cmd;
  logic                 act_ok, rw_ok, pre_hit, cont;
  logic                 err_set;
  logic [2:0]           err_code;
  logic                 acc_en, acc_wr;
  logic [1:0]           acc_bank;
  logic [ROW_IDX_W-1:0] acc_row;
  logic [COL_IDX_W-1:0] acc_col, col_nxt, bl_mask;
  logic [MEM_AW-1:0]    acc_idx;
  logic [15:0]          rd_word, rd_data;
  logic                 rd_push, rd_oe, wr_kill;
  logic                 unused_a;

  assign unused_a = ^sdr_A;

  always_comb begin
    cmd       = {sdr_nRAS, sdr_nCAS, sdr_nWE};
    cmd_en    = sdr_CKE && !sdr_nCS;
    any_open  = |bank_open;
    mrs_legal = (sdr_A[6:4] == 3'd2 || sdr_A[6:4] == 3'd3) && !sdr_A[2];
    act_ok    = 1'b0;
    rw_ok     = 1'b0;
    err_set   = 1'b0;
    err_code  = 3'd0;
    if (cmd_en) begin
      case (cmd)
        CMD_ACT: begin
          if (!mode_set)                   begin err_set = 1'b1; err_code = 3'd3; end
          else if (bank_open[sdr_BA])      begin err_set = 1'b1; err_code = 3'd2; end
          else                             act_ok = 1'b1;
        end
        CMD_READ, CMD_WRITE: begin
          if (!mode_set)                   begin err_set = 1'b1; err_code = 3'd3; end
          else if (!bank_open[sdr_BA])     begin err_set = 1'b1; err_code = 3'd1; end
          else                             rw_ok = 1'b1;
        end
        CMD_AREF: begin
          if (any_open)                    begin err_set = 1'b1; err_code = 3'd4; end
        end
        CMD_MRS: begin
          if (any_open)                    begin err_set = 1'b1; err_code = 3'd4; end
          else if (!mrs_legal)             begin err_set = 1'b1; err_code = 3'd5; end
        end
        default: ;
      endcase
    end
    pre_hit = cmd_en && (cmd == CMD_PRE) && (sdr_A[10] || sdr_BA == burst_bank);
    // A fresh READ/WRITE or a precharge of the bursting bank pre-empts the running burst.
    cont    = sdr_CKE && (burst_st != B_IDLE) && !rw_ok && !pre_hit;

    bl_mask = '0;
    for (int i = 0; i < 3; i++)
      if (2'(i) < bl_log) bl_mask[i] = 1'b1;

    acc_en   = 1'b0;
    acc_wr   = 1'b0;
    acc_bank = burst_bank;
    acc_row  = burst_row;
    acc_col  = burst_col;
    if (rw_ok) begin
      acc_en   = 1'b1;
      acc_wr   = (cmd == CMD_WRITE);
      acc_bank = sdr_BA;
      acc_row  = open_row[sdr_BA];
      acc_col  = sdr_A[COL_IDX_W-1:0];
    end else if (cont) begin
      acc_en   = 1'b1;
      acc_wr   = (burst_st == B_WRITE);
    end
    col_nxt = (acc_col & ~bl_mask) | ((acc_col + COL_IDX_W'(1)) & bl_mask);
    acc_idx = {acc_bank, acc_row, acc_col};
    rd_word = mem[acc_idx];
    rd_data = {sdr_DQM[1] ? 8'h00 : rd_word[15:8], sdr_DQM[0] ? 8'h00 : rd_word[7:0]};
    rd_push = acc_en && !acc_wr;
    rd_oe   = (sdr_DQM != 2'b11);
    wr_kill = rw_ok && (cmd == CMD_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_open     <= '0;
      mode_set      <= 1'b0;
      cl            <= 3'd3;
      bl_log        <= 2'd0;
      burst_st      <= B_IDLE;
      burst_left    <= 3'd0;
      burst_bank    <= 2'd0;
      vld_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      oe_p1         <= 1'b0;
      oe_p2         <= 1'b0;
      sdr_DQ_out    <= 16'h0000;
      sdr_DQ_oe     <= 1'b0;
      resp_err      <= 1'b0;
      resp_err_code <= 3'd0;
      aref_cnt      <= 16'h0000;
    end else if (sdr_CKE) begin
      if (err_set) begin
        resp_err <= 1'b1;
        if (!resp_err) resp_err_code <= err_code;
      end
      if (act_ok) bank_open[sdr_BA] <= 1'b1;
      if (cmd_en && cmd == CMD_PRE) begin
        if (sdr_A[10]) bank_open <= '0;
        else           bank_open[sdr_BA] <= 1'b0;
      end
      if (cmd_en && cmd == CMD_AREF && !any_open && aref_cnt != 16'hFFFF)
        aref_cnt <= aref_cnt + 16'd1;
      if (cmd_en && cmd == CMD_MRS && !any_open && mrs_legal) begin
        mode_set <= 1'b1;
        cl       <= sdr_A[6:4];
        bl_log   <= sdr_A[1:0];
      end

      if (rw_ok) begin
        burst_left <= bl_mask[2:0];
        burst_bank <= sdr_BA;
        if (bl_mask[2:0] == 3'd0)   burst_st <= B_IDLE;
        else if (cmd == CMD_WRITE)  burst_st <= B_WRITE;
        else                        burst_st <= B_READ;
      end else if (pre_hit) begin
        burst_st <= B_IDLE;
      end else if (cont) begin
        burst_left <= burst_left - 3'd1;
        if (burst_left == 3'd1) burst_st <= B_IDLE;
      end

      // read pipeline: p2 -> p1 -> pins; CL2 enters at p1, CL3 at p2
      if (wr_kill) begin
        vld_p1     <= 1'b0;
        vld_p2     <= 1'b0;
        sdr_DQ_oe  <= 1'b0;
        sdr_DQ_out <= 16'h0000;
      end else begin
        sdr_DQ_oe  <= vld_p1 && oe_p1;
        sdr_DQ_out <= (vld_p1 && oe_p1) ? data_p1 : 16'h0000;
        if (rd_push && cl == 3'd2) begin
          vld_p1 <= 1'b1;
          oe_p1  <= rd_oe;
        end else begin
          vld_p1 <= vld_p2;
          oe_p1  <= oe_p2;
        end
        vld_p2 <= rd_push && (cl == 3'd3);
        oe_p2  <= rd_oe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sdr_CKE) begin
      if (act_ok) open_row[sdr_BA] <= sdr_A[ROW_IDX_W-1:0];
      if (rw_ok)  burst_row <= open_row[sdr_BA];
      if (rw_ok || cont) burst_col <= col_nxt;
      data_p2 <= rd_data;
      data_p1 <= (rd_push && cl == 3'd2) ? rd_data : data_p2;
      if (acc_en && acc_wr) begin
        if (!sdr_DQM[0]) mem[acc_idx][7:0]  <= sdr_DQ_in[7:0];
        if (!sdr_DQM[1]) mem[acc_idx][15:8] <= sdr_DQ_in[15:8];
      end
    end
  end
endmodule

// File: tb/tb_sdr_cmd_responder.sv
// Directed bench for sdr_cmd_responder. Read beats are queued as expectations when a READ is issued.
// They are checked when due; every other cycle must show the data bus undriven.
module tb_sdr_cmd_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        cke, ncs, nras, ncas, nwe;
  logic [1:0]  ba, dqm;
  logic [12:0] a;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe, resp_err;
  logic [2:0]  resp_err_code;
  logic [15:0] aref_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic        oe;
    logic [15:0] data;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;

  sdr_cmd_responder #(.ROW_IDX_W(4), .COL_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .sdr_CKE(cke), .sdr_nCS(ncs), .sdr_BA(ba), .sdr_A(a),
    .sdr_nRAS(nras), .sdr_nCAS(ncas), .sdr_nWE(nwe), .sdr_DQM(dqm), .sdr_DQ_in(dq_in),
    .sdr_DQ_out(dq_out), .sdr_DQ_oe(dq_oe), .resp_err(resp_err),
    .resp_err_code(resp_err_code), .aref_cnt(aref_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    cke = 1'b1; ncs = 1'b0; {nras, ncas, nwe} = c;
    ba = b; a = addr; dqm = m; dq_in = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0000);
  endtask

  // READ sampled at edge t: beat k must be on the pins after edge t+cl-1+k
  task automatic expect_read(input int t, input int cl, input int k, input logic oe, input logic [15:0] d);
    exp_t e;
    e.due = t + cl - 1 + k; e.oe = oe; e.data = d;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      check("rd_oe", 32'(dq_oe), 32'(mon_e.oe));
      if (mon_e.oe) check("rd_data", 32'(dq_out), 32'(mon_e.data));
    end else begin
      check("idle_oe", 32'(dq_oe), 32'd0);
    end
  end

  initial begin
    int t, t2;
    rst = 1'b1; cke = 1'b1; ncs = 1'b1; {nras, ncas, nwe} = C_NOP;
    ba = 2'd0; a = 13'd0; dqm = 2'b00; dq_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_oe",   32'(dq_oe), 32'd0);
    check("rst_dq",   32'(dq_out), 32'd0);
    check("rst_err",  32'(resp_err), 32'd0);
    check("rst_code", 32'(resp_err_code), 32'd0);
    check("rst_aref", 32'(aref_cnt), 32'd0);
    rst = 1'b0;
    idle(2);
    check("post_rst_err",  32'(resp_err), 32'd0);
    check("post_rst_aref", 32'(aref_cnt), 32'd0);

    drive(C_ACT, 2'd0, 13'd0, 2'b00, 16'h0000);
    idle(1);
    check("early_act_err",  32'(resp_err), 32'd1);
    check("early_act_code", 32'(resp_err_code), 32'd3);

    drive(C_MRS, 2'd0, 13'h0032, 2'b00, 16'h0000);
    drive(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0000);
    drive(C_WR,  2'd1, 13'd6, 2'b00, 16'h0011);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0022);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0033);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h0044);
    idle(1);
    drive(C_RD, 2'd1, 13'd6, 2'b00, 16'h0000); t = cyc + 1;
    expect_read(t, 3, 0, 1'b1, 16'h0011);
    expect_read(t, 3, 1, 1'b1, 16'h0022);
    expect_read(t, 3, 2, 1'b1, 16'h0033);
    expect_read(t, 3, 3, 1'b1, 16'h0044);
    idle(8);

    drive(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0000);
    drive(C_MRS, 2'd0, 13'h0020, 2'b00, 16'h0000);
    drive(C_ACT, 2'd2, 13'd3, 2'b00, 16'h0000);
    drive(C_WR,  2'd2, 13'd1, 2'b00, 16'h1234);
    drive(C_WR,  2'd2, 13'd1, 2'b10, 16'hABCD);
    drive(C_RD,  2'd2, 13'd1, 2'b00, 16'h0000); t = cyc + 1;
    expect_read(t, 2, 0, 1'b1, 16'h12CD);
    drive(C_RD,  2'd2, 13'd1, 2'b01, 16'h0000); t = cyc + 1;
    expect_read(t, 2, 0, 1'b1, 16'h1200);
    drive(C_RD,  2'd2, 13'd1, 2'b11, 16'h0000); t = cyc + 1;
    expect_read(t, 2, 0, 1'b0, 16'h0000);
    idle(4);

    drive(C_PRE, 2'd0, 13'h0400, 2'b00, 16'h0000);
    drive(C_MRS, 2'd0, 13'h0032, 2'b00, 16'h0000);
    drive(C_ACT, 2'd1, 13'd5, 2'b00, 16'h0000);
    drive(C_RD,  2'd1, 13'd4, 2'b00, 16'h0000); t = cyc + 1;
    expect_read(t, 3, 0, 1'b1, 16'h0033);
    expect_read(t, 3, 1, 1'b0, 16'h0000);
    expect_read(t, 3, 2, 1'b1, 16'h0011);
    expect_read(t, 3, 3, 1'b1, 16'h0022);
    drive(C_NOP, 2'd0, 13'd0, 2'b11, 16'h0000);
    idle(7);

    drive(C_RD, 2'd1, 13'd4, 2'b00, 16'h0000); t = cyc + 1;
    expect_read(t, 3, 0, 1'b1, 16'h0033);
    expect_read(t, 3, 1, 1'b1, 16'h0044);
    idle(1);
    drive(C_RD, 2'd1, 13'd6, 2'b00, 16'h0000); t2 = cyc + 1;
    expect_read(t2, 3, 0, 1'b1, 16'h0011);
    expect_read(t2, 3, 1, 1'b1, 16'h0022);
    expect_read(t2, 3, 2, 1'b1, 16'h0033);
    expect_read(t2, 3, 3, 1'b1, 16'h0044);
    idle(7);

    drive(C_RD,  2'd1, 13'd4, 2'b00, 16'h0000);
    drive(C_WR,  2'd1, 13'd8, 2'b00, 16'h5555);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h6666);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h7777);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'h8888);
    idle(4);
    drive(C_RD, 2'd1, 13'd8, 2'b00, 16'h0000); t = cyc + 1;
    expect_read(t, 3, 0, 1'b1, 16'h5555);
    expect_read(t, 3, 1, 1'b1, 16'h6666);
    expect_read(t, 3, 2, 1'b1, 16'h7777);
    expect_read(t, 3, 3, 1'b1, 16'h8888);
    idle(7);

    @(negedge clk);
    rst = 1'b1; ncs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst2_err",  32'(resp_err), 32'd0);
    check("rst2_code", 32'(resp_err_code), 32'd0);
    drive(C_MRS, 2'd0, 13'h0032, 2'b00, 16'h0000);
    drive(C_RD,  2'd0, 13'd0, 2'b00, 16'h0000);
    idle(1);
    check("closed_rd_err",  32'(resp_err), 32'd1);
    check("closed_rd_code", 32'(resp_err_code), 32'd1);
    repeat (3) drive(C_REF, 2'd0, 13'd0, 2'b00, 16'h0000);
    idle(1);
    check("aref_cnt", 32'(aref_cnt), 32'd3);
    drive(C_ACT, 2'd0, 13'd2, 2'b00, 16'h0000);
    drive(C_MRS, 2'd0, 13'h0020, 2'b00, 16'h0000);
    drive(C_REF, 2'd0, 13'd0, 2'b00, 16'h0000);
    idle(1);
    check("open_mrs_err",  32'(resp_err), 32'd1);
    check("open_mrs_code", 32'(resp_err_code), 32'd1);
    check("open_aref_cnt", 32'(aref_cnt), 32'd3);
    drive(C_WR,  2'd0, 13'd0, 2'b00, 16'h9999);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'hAAAA);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'hBBBB);
    drive(C_NOP, 2'd0, 13'd0, 2'b00, 16'hCCCC);
    drive(C_RD,  2'd0, 13'd0, 2'b00, 16'h0000); t = cyc + 1;
    expect_read(t, 3, 0, 1'b1, 16'h9999);
    expect_read(t, 3, 1, 1'b1, 16'hAAAA);
    expect_read(t, 3, 2, 1'b1, 16'hBBBB);
    expect_read(t, 3, 3, 1'b1, 16'hCCCC);
    idle(7);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
